// File: rtl/snn_pkg.sv
// Shared definitions for the SNN packet network: opcodes, node IDs and the
// 33-bit packet layout exchanged between packetizer and depacketizer.
package snn_pkg;

  localparam int PKT_DEST_W = 4;
  localparam int PKT_OP_W   = 4;
  localparam int PKT_DATA_W = 25;
  localparam int PKT_W      = PKT_DEST_W + PKT_OP_W + PKT_DATA_W;

  localparam int PKT_DEST_MSB = 32;
  localparam int PKT_DEST_LSB = 29;
  localparam int PKT_OP_MSB   = 28;
  localparam int PKT_OP_LSB   = 25;
  localparam int PKT_DATA_MSB = 24;
  localparam int PKT_DATA_LSB = 0;

  localparam logic [PKT_OP_W-1:0] OP_WEIGHT        = 4'd0;
  localparam logic [PKT_OP_W-1:0] OP_INPUT         = 4'd1;
  localparam logic [PKT_OP_W-1:0] OP_TIMESTEP_DONE = 4'd15;

  localparam logic [PKT_DEST_W-1:0] IMEM_ID = 4'd11;

  typedef struct packed {
    logic [PKT_DEST_W-1:0] dest;
    logic [PKT_OP_W-1:0]   opcode;
    logic [PKT_DATA_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/imem_row_store.sv
// Binary ifmap row storage: synchronous write port, combinational read port.
// Out-of-range reads return zero and out-of-range writes are dropped.
module imem_row_store #(
  parameter int DEPTH  = 50,
  parameter int ROW_W  = 25,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ROW_W-1:0]  rd_data
);

  logic [ROW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// IMEM end of the PPE input-request protocol: primes each PPE with its first
// row, serves follow-up row requests and broadcasts timestep completion.
module imem_responder
  import snn_pkg::*;
#(
  parameter int IFMAP_SIZE  = 25,
  parameter int FILTER_SIZE = 5,
  parameter int NUM_TS      = 2,
  parameter int PPE_BASE_ID = 5,
  localparam int ADDR_W     = $clog2(NUM_TS * IFMAP_SIZE),
  localparam int TS_W       = (NUM_TS > 1) ? $clog2(NUM_TS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [IFMAP_SIZE-1:0] load_data,
  input  logic                  start,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_src,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [PKT_W-1:0]      pkt_data,
  output logic [TS_W-1:0]       ts_out,
  output logic                  done,
  output logic                  err
);

  localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int K_W        = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_SERVE, S_SEND, S_BCAST
  } state_t;

  state_t                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   req_ready_q, req_ready_d;
  logic                   pkt_valid_q, pkt_valid_d;
  pkt_t                   pkt_q, pkt_d;
  logic [CNT_W-1:0]       sent_q [FILTER_SIZE];
  logic [CNT_W-1:0]       sent_d [FILTER_SIZE];
  logic [FILTER_SIZE-1:0] trail_q, trail_d;

  logic [ADDR_W-1:0]      rd_addr;
  logic [IFMAP_SIZE-1:0]  rd_data;
  int                     rd_ts, rd_row;
  logic                   ld_in, ld_bc;
  int                     ld_k;
  logic                   pkt_fire, req_fire, src_in_range;
  int                     req_k;
  logic [CNT_W-1:0]       sent_sel;
  logic                   trail_sel;

  imem_row_store #(
    .DEPTH  (NUM_TS * IFMAP_SIZE),
    .ROW_W  (IFMAP_SIZE),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (load_en && (state_q == S_IDLE)),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_addr  = ADDR_W'(rd_ts * IFMAP_SIZE + rd_row);
  assign pkt_fire = pkt_valid_q && pkt_ready;
  assign req_fire = req_valid && req_ready_q;

  // Decode the requester into a PPE index and look up its progress.
  always_comb begin
    req_k        = int'(req_src) - PPE_BASE_ID;
    src_in_range = (req_k >= 0) && (req_k < FILTER_SIZE);
    sent_sel     = '0;
    trail_sel    = 1'b0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      if (i == req_k) begin
        sent_sel  = sent_q[i];
        trail_sel = trail_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ts_d        = ts_q;
    done_d      = done_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    pkt_valid_d = pkt_valid_q;
    pkt_d       = pkt_q;
    sent_d      = sent_q;
    trail_d     = trail_q;
    rd_ts       = int'(ts_q);
    rd_row      = 0;
    ld_in       = 1'b0;
    ld_bc       = 1'b0;
    ld_k        = 0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ts_d        = '0;
          done_d      = 1'b0;
          k_d         = '0;
          trail_d     = '0;
          for (int i = 0; i < FILTER_SIZE; i++) sent_d[i] = '0;
          rd_ts       = 0;
          ld_in       = 1'b1;
          pkt_valid_d = 1'b1;
          state_d     = S_PRIME;
        end
      end
      S_PRIME: begin
        if (pkt_fire) begin
          sent_d[k_q] = CNT_W'(1);
          if (int'(k_q) == FILTER_SIZE - 1) begin
            pkt_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = S_SERVE;
          end else begin
            k_d    = k_q + K_W'(1);
            ld_k   = int'(k_q) + 1;
            rd_row = ld_k;
            ld_in  = 1'b1;
          end
        end
      end
      S_SERVE: begin
        if (req_fire) begin
          if (!src_in_range || trail_sel) begin
            err_d = 1'b1;
          end else if (int'(sent_sel) < OUTPUT_DIM) begin
            ld_k        = req_k;
            rd_row      = req_k + int'(sent_sel);
            ld_in       = 1'b1;
            pkt_valid_d = 1'b1;
            req_ready_d = 1'b0;
            state_d     = S_SEND;
            for (int i = 0; i < FILTER_SIZE; i++) begin
              if (i == req_k) sent_d[i] = sent_sel + CNT_W'(1);
            end
          end else begin
            // Trailing request: absorbed, completes the PPE for this timestep.
            for (int i = 0; i < FILTER_SIZE; i++) begin
              if (i == req_k) trail_d[i] = 1'b1;
            end
            if (&trail_d) begin
              k_d         = '0;
              ld_bc       = 1'b1;
              pkt_valid_d = 1'b1;
              req_ready_d = 1'b0;
              state_d     = S_BCAST;
            end
          end
        end
      end
      S_SEND: begin
        if (pkt_fire) begin
          pkt_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_SERVE;
        end
      end
      S_BCAST: begin
        if (pkt_fire) begin
          if (int'(k_q) < FILTER_SIZE - 1) begin
            k_d   = k_q + K_W'(1);
            ld_k  = int'(k_q) + 1;
            ld_bc = 1'b1;
          end else if (int'(ts_q) < NUM_TS - 1) begin
            ts_d    = ts_q + TS_W'(1);
            k_d     = '0;
            trail_d = '0;
            for (int i = 0; i < FILTER_SIZE; i++) sent_d[i] = '0;
            rd_ts   = int'(ts_q) + 1;
            ld_in   = 1'b1;
            state_d = S_PRIME;
          end else begin
            done_d      = 1'b1;
            pkt_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ld_in) begin
      pkt_d.dest   = PKT_DEST_W'(PPE_BASE_ID + ld_k);
      pkt_d.opcode = OP_INPUT;
      pkt_d.data   = PKT_DATA_W'(rd_data);
    end else if (ld_bc) begin
      pkt_d.dest   = PKT_DEST_W'(PPE_BASE_ID + ld_k);
      pkt_d.opcode = OP_TIMESTEP_DONE;
      pkt_d.data   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      ts_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_q       <= '0;
      trail_q     <= '0;
      for (int i = 0; i < FILTER_SIZE; i++) sent_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ts_q        <= ts_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_q       <= pkt_d;
      trail_q     <= trail_d;
      for (int i = 0; i < FILTER_SIZE; i++) sent_q[i] <= sent_d[i];
    end
  end

  assign req_ready = req_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_q;
  assign ts_out    = ts_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
